h_est_buffer: RTL and testbench

Ping-pong buffer directly downstream of the channel-estimate interpolation stage. Each beat accepts the two interpolated complex estimates that stage produces (h_eqlz_1, h_eqlz_2), assembles a full NB-IoT PRB of 12 subcarrier estimates per bank, and serves them one per cycle, in subcarrier order, to the equalizer over a valid/ready handshake. Two banks let the interpolator fill one PRB while the equalizer drains the other.

---
 rtl/h_est_buffer_pkg.sv | 7 +
 rtl/h_est_buffer_est_bank.sv | 39 +++
 rtl/h_est_buffer.sv | 84 ++++++++
 tb/tb_h_est_buffer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/h_est_buffer_pkg.sv
// h_est_buffer_pkg: shared defaults and bank state encoding for the estimate ping-pong buffer
package h_est_buffer_pkg;
    localparam int N_SC_DEF = 12;
    localparam int WIDTH_DEF = 17;
    localparam int IDX_WIDTH_DEF = 4;
    typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_t;
endpackage

// File: rtl/h_est_buffer_est_bank.sv
// est_bank: N_SC-entry complex register file, even/odd pair write port, asynchronous read port
module est_bank import h_est_buffer_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int N_SC = N_SC_DEF,
    parameter int IDX_WIDTH = IDX_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 we,
    input  logic [IDX_WIDTH-1:0] wr_beat,
    input  logic [WIDTH-1:0]     h1_r,
    input  logic [WIDTH-1:0]     h1_i,
    input  logic [WIDTH-1:0]     h2_r,
    input  logic [WIDTH-1:0]     h2_i,
    input  logic [IDX_WIDTH-1:0] rd_idx,
    output logic [WIDTH-1:0]     rd_r,
    output logic [WIDTH-1:0]     rd_i
);
    logic [WIDTH-1:0] mem_r [N_SC];
    logic [WIDTH-1:0] mem_i [N_SC];
    logic [IDX_WIDTH-1:0] even_idx, odd_idx;
    assign even_idx = {wr_beat[IDX_WIDTH-2:0], 1'b0};
    assign odd_idx = {wr_beat[IDX_WIDTH-2:0], 1'b1};
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int k = 0; k < N_SC; k++) begin
                mem_r[k] <= '0;
                mem_i[k] <= '0;
            end
        end else if (we) begin
            mem_r[even_idx] <= h1_r;
            mem_i[even_idx] <= h1_i;
            mem_r[odd_idx] <= h2_r;
            mem_i[odd_idx] <= h2_i;
        end
    end
    assign rd_r = mem_r[rd_idx];
    assign rd_i = mem_i[rd_idx];
endmodule

// File: rtl/h_est_buffer.sv
// h_est_buffer: two-bank ping-pong buffer assembling PRBs of channel estimates and serving them one per cycle
module h_est_buffer import h_est_buffer_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int N_SC = N_SC_DEF,
    parameter int IDX_WIDTH = IDX_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     h1_r,
    input  logic [WIDTH-1:0]     h1_i,
    input  logic [WIDTH-1:0]     h2_r,
    input  logic [WIDTH-1:0]     h2_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_r,
    output logic [WIDTH-1:0]     out_i,
    output logic [IDX_WIDTH-1:0] out_idx,
    output logic                 out_last,
    output logic                 overflow
);
    bank_state_t state [2];
    logic wr_bank, rd_bank, clr, wr_fire, wr_done, rd_fire, rd_done;
    logic [IDX_WIDTH-1:0] wr_beat, rd_idx;
    logic [WIDTH-1:0] bank_r [2];
    logic [WIDTH-1:0] bank_i [2];
    assign clr = rst || flush;
    assign in_ready = state[wr_bank] != FULL;
    assign out_valid = state[rd_bank] == FULL;
    assign wr_fire = in_valid && in_ready;
    assign wr_done = wr_fire && wr_beat == IDX_WIDTH'(N_SC / 2 - 1);
    assign rd_fire = out_valid && out_ready;
    assign rd_done = rd_fire && rd_idx == IDX_WIDTH'(N_SC - 1);
    // A FULL bank is never writable, so write and read-complete never target the same bank
    always_ff @(posedge clk) begin
        if (clr) begin
            state[0] <= EMPTY;
            state[1] <= EMPTY;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_beat <= '0;
            rd_idx <= '0;
            overflow <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (wr_fire && wr_bank == 1'(b))
                    state[b] <= wr_done ? FULL : FILLING;
                else if (rd_done && rd_bank == 1'(b))
                    state[b] <= EMPTY;
            end
            if (wr_fire) begin
                wr_beat <= wr_done ? '0 : wr_beat + 1'b1;
                wr_bank <= wr_bank ^ wr_done;
            end
            if (rd_fire) begin
                rd_idx <= rd_done ? '0 : rd_idx + 1'b1;
                rd_bank <= rd_bank ^ rd_done;
            end
            if (in_valid && !in_ready)
                overflow <= 1'b1;
        end
    end
    for (genvar g = 0; g < 2; g++) begin : g_bank
        est_bank #(.WIDTH(WIDTH), .N_SC(N_SC), .IDX_WIDTH(IDX_WIDTH)) u_bank (
            .clk(clk),
            .clr(clr),
            .we(wr_fire && wr_bank == 1'(g)),
            .wr_beat(wr_beat),
            .h1_r(h1_r),
            .h1_i(h1_i),
            .h2_r(h2_r),
            .h2_i(h2_i),
            .rd_idx(rd_idx),
            .rd_r(bank_r[g]),
            .rd_i(bank_i[g])
        );
    end
    assign out_r = bank_r[rd_bank];
    assign out_i = bank_i[rd_bank];
    assign out_idx = rd_idx;
    assign out_last = out_valid && rd_idx == IDX_WIDTH'(N_SC - 1);
endmodule

// File: tb/tb_h_est_buffer.sv
// tb_h_est_buffer: scoreboard bench for the estimate ping-pong buffer
module tb_h_est_buffer;
    localparam int W = 17;
    localparam int N = 12;
    logic clk = 1'b0;
    logic rst, flush, in_valid, in_ready, out_valid, out_ready, out_last, overflow;
    logic signed [W-1:0] h1_r, h1_i, h2_r, h2_i, out_r, out_i;
    logic [3:0] out_idx;
    typedef struct {
        logic signed [W-1:0] r;
        logic signed [W-1:0] i;
        int idx;
    } exp_t;
    exp_t q[$];
    exp_t e;
    int sb_idx = 0;
    int checks = 0;
    int errors = 0;

    h_est_buffer dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .h1_r(h1_r), .h1_i(h1_i), .h2_r(h2_r), .h2_i(h2_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_i(out_i), .out_idx(out_idx),
        .out_last(out_last), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic rdy, input logic signed [W-1:0] ar, ai, br, bi,
                         output logic acc);
        @(negedge clk);
        in_valid = v;
        out_ready = rdy;
        h1_r = ar;
        h1_i = ai;
        h2_r = br;
        h2_i = bi;
        acc = v && in_ready;
        if (acc) begin
            q.push_back('{ar, ai, sb_idx});
            q.push_back('{br, bi, sb_idx + 1});
            sb_idx = (sb_idx + 2) % N;
        end
    endtask

    task automatic drive_rand(input logic v, input logic rdy, output logic acc);
        drive(v, rdy, W'($urandom), W'($urandom), W'($urandom), W'($urandom), acc);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        {h1_r, h1_i, h2_r, h2_i} = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, overflow, out_last} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags got in_ready=%b out_valid=%b overflow=%b out_last=%b exp 1 0 0 0",
                     in_ready, out_valid, overflow, out_last);
        end
        checks++;
        if (out_r !== 0 || out_i !== 0 || out_idx !== 0) begin
            errors++;
            $display("FAIL reset_data got r=%0d i=%0d idx=%0d exp 0 0 0", out_r, out_i, out_idx);
        end
        rst = 1'b0;
        sb_idx = 0;
        q.delete();
    endtask

    task automatic test_single_prb;
        logic acc;
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 1'b0, W'(2 * k), W'(-2 * k), W'(2 * k + 1), W'(-(2 * k + 1)), acc);
            checks++;
            if (out_valid !== 1'b0 || acc !== 1'b1) begin
                errors++;
                $display("FAIL single_fill beat %0d got out_valid=%b accepted=%b exp 0 1", k, out_valid, acc);
            end
        end
        for (int n = 0; n < 20 && (q.size() > 0 || n == 0); n++) begin
            drive(1'b0, 1'b1, '0, '0, '0, '0, acc);
            if (n == 0) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL single_latency got out_valid=%b exp 1", out_valid);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL single_extra got idx=%0d exp no output", out_idx);
                end else begin
                    e = q.pop_front();
                    if (out_r !== e.r || out_i !== e.i || out_idx !== 4'(e.idx) || out_last !== (e.idx == N - 1) ||
                        out_r !== W'(e.idx) || out_i !== W'(-e.idx)) begin
                        errors++;
                        $display("FAIL single_data got r=%0d i=%0d idx=%0d last=%b exp r=%0d i=%0d idx=%0d",
                                 out_r, out_i, out_idx, out_last, e.r, e.i, e.idx);
                    end
                end
            end
        end
        drive(1'b0, 1'b1, '0, '0, '0, '0, acc);
        checks++;
        if (q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_end got pending=%0d out_valid=%b exp 0 0", q.size(), out_valid);
        end
    endtask

    task automatic test_overflow;
        logic acc;
        for (int k = 0; k < 12; k++) begin
            drive_rand(1'b1, 1'b0, acc);
            checks++;
            if (acc !== 1'b1) begin
                errors++;
                $display("FAIL ovf_fill beat %0d got in_ready=%b exp 1", k, in_ready);
            end
        end
        drive_rand(1'b1, 1'b0, acc);
        checks++;
        if (in_ready !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_full got in_ready=%b overflow=%b exp 0 0", in_ready, overflow);
        end
        for (int n = 0; n < 40 && (q.size() > 0 || n == 0); n++) begin
            drive(1'b0, 1'b1, '0, '0, '0, '0, acc);
            if (n == 0) begin
                checks++;
                if (overflow !== 1'b1) begin
                    errors++;
                    $display("FAIL ovf_flag got overflow=%b exp 1", overflow);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL ovf_extra got idx=%0d exp no output", out_idx);
                end else begin
                    e = q.pop_front();
                    if (out_r !== e.r || out_i !== e.i || out_idx !== 4'(e.idx) || out_last !== (e.idx == N - 1)) begin
                        errors++;
                        $display("FAIL ovf_data got r=%0d i=%0d idx=%0d last=%b exp r=%0d i=%0d idx=%0d",
                                 out_r, out_i, out_idx, out_last, e.r, e.i, e.idx);
                    end
                end
            end
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL ovf_drain got pending=%0d exp 0", q.size());
        end
        @(negedge clk);
        flush = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        sb_idx = 0;
        checks++;
        if (overflow !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear got overflow=%b in_ready=%b out_valid=%b exp 0 1 0", overflow, in_ready, out_valid);
        end
    endtask

    task automatic test_interleaved;
        logic acc, stalled;
        logic signed [W-1:0] sr, si;
        logic [3:0] sx;
        int sent = 0;
        int cyc = 0;
        stalled = 1'b0;
        {sr, si, sx} = '0;
        while (cyc < 300 && (sent < 12 || q.size() > 0)) begin
            drive_rand(sent < 12, cyc[0], acc);
            if (acc) sent++;
            if (stalled) begin
                checks++;
                if (out_r !== sr || out_i !== si || out_idx !== sx || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL inter_stall got r=%0d i=%0d idx=%0d exp r=%0d i=%0d idx=%0d",
                             out_r, out_i, out_idx, sr, si, sx);
                end
            end
            stalled = out_valid && !out_ready;
            {sr, si, sx} = {out_r, out_i, out_idx};
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL inter_extra got idx=%0d exp no output", out_idx);
                end else begin
                    e = q.pop_front();
                    if (out_r !== e.r || out_i !== e.i || out_idx !== 4'(e.idx) || out_last !== (e.idx == N - 1)) begin
                        errors++;
                        $display("FAIL inter_data got r=%0d i=%0d idx=%0d last=%b exp r=%0d i=%0d idx=%0d",
                                 out_r, out_i, out_idx, out_last, e.r, e.i, e.idx);
                    end
                end
            end
            cyc++;
        end
        drive(1'b0, 1'b0, '0, '0, '0, '0, acc);
        checks++;
        if (sent != 12 || q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL inter_end got sent=%0d pending=%0d out_valid=%b exp 12 0 0", sent, q.size(), out_valid);
        end
    endtask

    task automatic test_simultaneous;
        logic acc;
        for (int k = 0; k < 6; k++) drive_rand(1'b1, 1'b0, acc);
        for (int c = 0; c < 12; c++) begin
            drive_rand(c >= 6, 1'b1, acc);
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL simul_extra got idx=%0d exp no output", out_idx);
                end else begin
                    e = q.pop_front();
                    if (out_r !== e.r || out_i !== e.i || out_idx !== 4'(e.idx) || out_last !== (e.idx == N - 1)) begin
                        errors++;
                        $display("FAIL simul_data got r=%0d i=%0d idx=%0d last=%b exp r=%0d i=%0d idx=%0d",
                                 out_r, out_i, out_idx, out_last, e.r, e.i, e.idx);
                    end
                end
            end
        end
        drive(1'b0, 1'b0, '0, '0, '0, '0, acc);
        checks++;
        if (q.size() != 12) begin
            errors++;
            $display("FAIL simul_count got pending=%0d exp 12", q.size());
        end else if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_idx !== 0 || out_r !== q[0].r || out_i !== q[0].i) begin
            errors++;
            $display("FAIL simul_switch got in_ready=%b out_valid=%b idx=%0d r=%0d exp 1 1 0 r=%0d",
                     in_ready, out_valid, out_idx, out_r, q[0].r);
        end
        for (int n = 0; n < 20 && q.size() > 0; n++) begin
            drive(1'b0, 1'b1, '0, '0, '0, '0, acc);
            if (out_valid && out_ready) begin
                checks++;
                e = q.pop_front();
                if (out_r !== e.r || out_i !== e.i || out_idx !== 4'(e.idx) || out_last !== (e.idx == N - 1)) begin
                    errors++;
                    $display("FAIL simul_drain got r=%0d i=%0d idx=%0d last=%b exp r=%0d i=%0d idx=%0d",
                             out_r, out_i, out_idx, out_last, e.r, e.i, e.idx);
                end
            end
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL simul_end got pending=%0d exp 0", q.size());
        end
    endtask

    task automatic test_flush;
        logic acc;
        for (int k = 0; k < 3; k++) drive_rand(1'b1, 1'b0, acc);
        @(negedge clk);
        flush = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        q.delete();
        sb_idx = 0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_state got out_valid=%b in_ready=%b exp 0 1", out_valid, in_ready);
        end
        for (int k = 0; k < 6; k++) drive_rand(1'b1, 1'b0, acc);
        for (int n = 0; n < 20 && q.size() > 0; n++) begin
            drive(1'b0, 1'b1, '0, '0, '0, '0, acc);
            if (out_valid && out_ready) begin
                checks++;
                e = q.pop_front();
                if (out_r !== e.r || out_i !== e.i || out_idx !== 4'(e.idx) || out_last !== (e.idx == N - 1)) begin
                    errors++;
                    $display("FAIL flush_data got r=%0d i=%0d idx=%0d last=%b exp r=%0d i=%0d idx=%0d",
                             out_r, out_i, out_idx, out_last, e.r, e.i, e.idx);
                end
            end
        end
        drive(1'b0, 1'b0, '0, '0, '0, '0, acc);
        checks++;
        if (q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_end got pending=%0d out_valid=%b exp 0 0", q.size(), out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_prb();
        test_overflow();
        test_interleaved();
        test_simultaneous();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
